// File: rtl/mcycle_pkg.sv
// Shared types and op encodings for the multi-cycle multiply/divide sequencer.
package mcycle_pkg;
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    localparam logic MC_MUL = 1'b0;
    localparam logic MC_DIV = 1'b1;
endpackage

// File: rtl/mcycle_seq_if.sv
// Request/result bundle between the control unit and the multiply/divide sequencer.
interface mcycle_seq_if #(parameter int WIDTH = 32);
    logic             Start;
    logic             MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;

    modport master (output Start, MCycleOp, Operand1, Operand2,
                    input  Result1, Result2, Busy, Done);
    modport slave  (input  Start, MCycleOp, Operand1, Operand2,
                    output Result1, Result2, Busy, Done);
endinterface

// File: rtl/mcycle_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on {hi,lo}.
module mcycle_step
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             op,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;
    logic           take;

    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        rem_sh = {hi, lo[WIDTH-1]};
        trial  = rem_sh - {1'b0, opnd};
        // A bit shifted out of rem means it already exceeds any divisor, so the
        // subtract always succeeds and the low WIDTH bits of trial are exact.
        take   = rem_sh[WIDTH] | ~trial[WIDTH];
        if (op == MC_DIV) begin
            hi_nxt = take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], take};
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mcycle_seq.sv
// Multi-cycle MUL/DIV sequencer: FSM, iteration counter, accumulator and result registers.
module mcycle_seq
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         CLK,
    input  logic         RESETn,
    mcycle_seq_if.slave  bus
);
    localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             op_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic [WIDTH-1:0] res1_q, res2_q;
    logic             load, last, busy, done;

    mcycle_step #(.WIDTH(WIDTH)) u_step (
        .op     (op_q),
        .hi     (hi_q),
        .lo     (lo_q),
        .opnd   (opnd_q),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        last      = (cnt == LAST);
        case (state)
            IDLE: if (bus.Start) begin
                load      = 1'b1;
                busy      = 1'b1;
                state_nxt = COMPUTE;
            end
            COMPUTE: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (bus.Start) begin
                    load      = 1'b1;
                    busy      = 1'b1;
                    state_nxt = COMPUTE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Multiply keeps the multiplicand as the step operand; divide keeps the divisor.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt    <= '0;
            op_q   <= MC_MUL;
            opnd_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            res1_q <= '0;
            res2_q <= '0;
        end else if (load) begin
            cnt    <= '0;
            op_q   <= bus.MCycleOp;
            hi_q   <= '0;
            lo_q   <= (bus.MCycleOp == MC_DIV) ? bus.Operand1 : bus.Operand2;
            opnd_q <= (bus.MCycleOp == MC_DIV) ? bus.Operand2 : bus.Operand1;
        end else if (state == COMPUTE) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            if (last) begin
                res1_q <= lo_nxt;
                res2_q <= hi_nxt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.Busy    = busy;
    assign bus.Done    = done;
    assign bus.Result1 = res1_q;
    assign bus.Result2 = res2_q;
endmodule

// File: tb/tb_mcycle_seq.sv
// Vector-table bench for mcycle_seq with a result scoreboard and reset/chain/noise sequences.
module tb_mcycle_seq;
    import mcycle_pkg::*;

    localparam int W = 32;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    always #5 CLK = ~CLK;

    mcycle_seq_if #(.WIDTH(W)) bus();
    mcycle_seq #(.WIDTH(W)) dut (.CLK(CLK), .RESETn(RESETn), .bus(bus));

    typedef struct {
        logic         op;
        logic [W-1:0] a, b, r1, r2;
        bit           noise, chain;
    } vec_t;
    typedef struct { logic [W-1:0] r1, r2; } exp_t;

    localparam int NV = 10;
    vec_t tbl [NV];
    exp_t sb [$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Call just after a negedge; the request is sampled at the next posedge.
    task automatic start_op(input vec_t v);
        bus.Start    = 1'b1;
        bus.MCycleOp = v.op;
        bus.Operand1 = v.a;
        bus.Operand2 = v.b;
        sb.push_back(exp_t'{v.r1, v.r2});
        #1 chk("busy_at_start", 64'(bus.Busy), 64'd1);
    endtask

    task automatic finish_op(input bit noise, input bit chain, input vec_t nxt);
        int           cyc;
        bit           seen = 0, busy_ok = 1, hold_ok = 1;
        logic [W-1:0] h1, h2;
        exp_t         e;
        h1 = bus.Result1;
        h2 = bus.Result2;
        for (cyc = 1; cyc <= W + 4; cyc++) begin
            @(negedge CLK);
            if (bus.Done) begin
                seen = 1;
                break;
            end
            if (!bus.Busy) busy_ok = 0;
            if (bus.Result1 !== h1 || bus.Result2 !== h2) hold_ok = 0;
            bus.Start = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
                bus.MCycleOp = 1'($urandom);
                bus.Operand1 = $urandom;
                bus.Operand2 = $urandom;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("latency", 64'(cyc), 64'(W + 1));
        chk("busy_during_compute", 64'(busy_ok), 64'd1);
        chk("results_held_during_compute", 64'(hold_ok), 64'd1);
        chk("scoreboard_nonempty", 64'(sb.size() > 0), 64'd1);
        e = '{default: '0};
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("result1", 64'(bus.Result1), 64'(e.r1));
            chk("result2", 64'(bus.Result2), 64'(e.r2));
        end
        if (chain) begin
            start_op(nxt);
        end else begin
            bus.Start = 1'b0;
            #1 chk("busy_low_in_done", 64'(bus.Busy), 64'd0);
            @(negedge CLK);
            chk("done_single_pulse", 64'(bus.Done), 64'd0);
            chk("result1_hold_idle", 64'(bus.Result1), 64'(e.r1));
            chk("result2_hold_idle", 64'(bus.Result2), 64'(e.r2));
        end
    endtask

    initial begin
        bit   no_done;
        vec_t v;

        tbl[0] = vec_t'{MC_MUL, 32'd7,          32'd6,          32'd42,         32'd0,          1'b0, 1'b0};
        tbl[1] = vec_t'{MC_MUL, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFE,  1'b0, 1'b0};
        tbl[2] = vec_t'{MC_DIV, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
        tbl[3] = vec_t'{MC_DIV, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b0, 1'b1};
        tbl[4] = vec_t'{MC_DIV, 32'd9,          32'd2,          32'd4,          32'd1,          1'b0, 1'b0};
        tbl[5] = vec_t'{MC_MUL, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  32'd1,          1'b1, 1'b0};
        tbl[6] = vec_t'{MC_DIV, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0, 1'b0};
        tbl[7] = vec_t'{MC_DIV, 32'd0,          32'd3,          32'd0,          32'd0,          1'b0, 1'b0};
        tbl[8] = vec_t'{MC_MUL, 32'h0001_0000,  32'h0001_0000,  32'd0,          32'd1,          1'b0, 1'b0};
        tbl[9] = vec_t'{MC_DIV, 32'd1000,       32'd10,         32'd100,        32'd0,          1'b1, 1'b0};

        bus.Start    = 1'b0;
        bus.MCycleOp = MC_MUL;
        bus.Operand1 = '0;
        bus.Operand2 = '0;

        #12;
        chk("reset_busy", 64'(bus.Busy), 64'd0);
        chk("reset_done", 64'(bus.Done), 64'd0);
        chk("reset_result1", 64'(bus.Result1), 64'd0);
        chk("reset_result2", 64'(bus.Result2), 64'd0);
        @(negedge CLK);
        RESETn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (i == 0 || !tbl[i-1].chain) begin
                @(negedge CLK);
                start_op(tbl[i]);
            end
            finish_op(tbl[i].noise, tbl[i].chain, tbl[(i + 1) % NV]);
        end

        // Reset in the middle of an operation: everything clears and no Done follows.
        @(negedge CLK);
        v = vec_t'{MC_MUL, 32'd11, 32'd13, 32'd143, 32'd0, 1'b0, 1'b0};
        start_op(v);
        for (int k = 0; k < 11; k++) begin
            @(negedge CLK);
            bus.Start = 1'b0;
        end
        RESETn = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("midreset_busy", 64'(bus.Busy), 64'd0);
        chk("midreset_done", 64'(bus.Done), 64'd0);
        chk("midreset_result1", 64'(bus.Result1), 64'd0);
        chk("midreset_result2", 64'(bus.Result2), 64'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        no_done = 1;
        for (int k = 0; k < W + 8; k++) begin
            @(negedge CLK);
            if (bus.Done || bus.Busy) no_done = 0;
        end
        chk("no_done_after_reset", 64'(no_done), 64'd1);

        @(negedge CLK);
        v = vec_t'{MC_MUL, 32'd3, 32'd5, 32'd15, 32'd0, 1'b0, 1'b0};
        start_op(v);
        finish_op(1'b0, 1'b0, v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
